// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: register map, frame constants, FSM encoding and readback mux for spi_reg_ctrl.
package spi_reg_pkg;
   localparam logic [7:0] ADDR_LED  = 8'h07;
   localparam logic [7:0] ADDR_MUX  = 8'h08;
   localparam logic [7:0] ADDR_DAC  = 8'h09;
   localparam logic [7:0] ADDR_ERR  = 8'h0A;
   localparam logic [7:0] ADDR_DRST = 8'h0B;
   localparam logic [7:0] ADDR_SRST = 8'h0F;
   localparam logic [7:0] SRST_KEY  = 8'hA5;
   localparam logic [4:0] FRAME_BITS = 5'd16;
   localparam logic [4:0] CNT_SAT    = 5'd17;

   typedef enum logic [1:0] {S_WAIT, S_IDLE, S_SHIFT, S_DONE} state_t;

   function automatic logic [7:0] rd_data(input logic [6:0] a, input logic [7:0] led, input logic [7:0] mux,
                                          input logic [3:0] dac, input logic [7:0] err);
      return a == ADDR_LED[6:0] ? led :
             a == ADDR_MUX[6:0] ? mux :
             a == ADDR_DAC[6:0] ? {4'h0, dac} :
             a == ADDR_ERR[6:0] ? err : 8'h00;
   endfunction
endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: synchronises the async SPI inputs and detects spi_clk/spi_cs edges.
// sclk_rise exists only when SPI_READBACK_EN is defined.
module spi_in_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic spi_clk,
   input  logic spi_cs,
   input  logic spi_special,
   input  logic spi_mosi,
   output logic cs,
   output logic special,
   output logic mosi,
   output logic sclk_fall,
   output logic cs_rise
`ifdef SPI_READBACK_EN
   ,
   output logic sclk_rise
`endif
);
   logic [SYNC_STAGES-1:0] s_clk, s_cs, s_special, s_mosi;

   // No reset: the chains keep tracking the pins so a released reset sees the live cs level.
   always_ff @(posedge clk) begin
      s_clk     <= {s_clk[SYNC_STAGES-2:0], spi_clk};
      s_cs      <= {s_cs[SYNC_STAGES-2:0], spi_cs};
      s_special <= {s_special[SYNC_STAGES-2:0], spi_special};
      s_mosi    <= {s_mosi[SYNC_STAGES-2:0], spi_mosi};
   end

   assign cs        = s_cs[SYNC_STAGES-1];
   assign special   = s_special[SYNC_STAGES-1];
   assign mosi      = s_mosi[SYNC_STAGES-1];
   assign sclk_fall = s_clk[SYNC_STAGES-1] & ~s_clk[SYNC_STAGES-2];
   assign cs_rise   = ~s_cs[SYNC_STAGES-1] & s_cs[SYNC_STAGES-2];
`ifdef SPI_READBACK_EN
   assign sclk_rise = ~s_clk[SYNC_STAGES-1] & s_clk[SYNC_STAGES-2];
`endif
endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: validates 16-bit SPI frames and owns the mux/LED/DAC registers and DAC reset pulse.
// Defining SPI_READBACK_EN adds register readback on spi_miso.
module spi_reg_ctrl #(
   parameter int         SYNC_STAGES   = 2,
   parameter int         RST_PULSE_LEN = 16,
   parameter logic [3:0] DAC_RESET_VAL = 4'h2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_clk,
   input  logic       spi_cs,
   input  logic       spi_special,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic [7:0] reg_mux,
   output logic [7:0] reg_led,
   output logic [3:0] reg_dac,
   output logic       dac_rst_n,
   output logic       frame_err
);
   import spi_reg_pkg::*;

   localparam logic [7:0] PULSE = 8'(RST_PULSE_LEN);

   logic cs_s, special_s, mosi_s, sclk_fall, cs_rise;
   state_t state;
   logic [4:0] cnt;
   logic [15:0] sh;
   logic [7:0] err_cnt, pcnt;

`ifdef SPI_READBACK_EN
   logic sclk_rise;
`endif

   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk),
      .spi_clk(spi_clk),
      .spi_cs(spi_cs),
      .spi_special(spi_special),
      .spi_mosi(spi_mosi),
      .cs(cs_s),
      .special(special_s),
      .mosi(mosi_s),
      .sclk_fall(sclk_fall),
      .cs_rise(cs_rise)
`ifdef SPI_READBACK_EN
      ,
      .sclk_rise(sclk_rise)
`endif
   );

   always_ff @(posedge clk) begin
      frame_err <= 1'b0;
      if (!rst_n) begin
         state     <= S_WAIT;
         cnt       <= '0;
         sh        <= '0;
         err_cnt   <= '0;
         pcnt      <= '0;
         reg_mux   <= '0;
         reg_led   <= '0;
         reg_dac   <= DAC_RESET_VAL;
         dac_rst_n <= 1'b1;
      end else begin
         if (pcnt != 8'd0) begin
            pcnt      <= pcnt - 8'd1;
            dac_rst_n <= pcnt == 8'd1;
         end
         case (state)
            S_WAIT: if (cs_s) state <= S_IDLE;
            S_IDLE: if (!cs_s && !special_s) begin
               state <= S_SHIFT;
               cnt   <= '0;
               sh    <= '0;
            end
            S_SHIFT: if (!cs_s && special_s) begin
               frame_err <= 1'b1;
               state     <= S_WAIT;
            end else if (cs_rise) begin
               state <= S_DONE;
            end else if (sclk_fall) begin
               sh  <= {sh[14:0], mosi_s};
               cnt <= cnt + {4'd0, cnt != CNT_SAT};
            end
            S_DONE: begin
               state <= S_IDLE;
               if (cnt == FRAME_BITS) begin
                  // Read frames carry addr[7]=1 and so never match a write address.
                  case (sh[15:8])
                     ADDR_LED:  reg_led <= sh[7:0];
                     ADDR_MUX:  reg_mux <= sh[7:0];
                     ADDR_DAC:  reg_dac <= sh[3:0];
                     ADDR_DRST: if (sh[0]) begin
                        pcnt      <= PULSE;
                        dac_rst_n <= 1'b0;
                     end
                     ADDR_SRST: if (sh[7:0] == SRST_KEY) begin
                        reg_mux   <= '0;
                        reg_led   <= '0;
                        reg_dac   <= DAC_RESET_VAL;
                        pcnt      <= '0;
                        dac_rst_n <= 1'b1;
                     end
                     default: ;
                  endcase
               end else begin
                  frame_err <= 1'b1;
                  err_cnt   <= err_cnt + {7'd0, err_cnt != 8'hFF};
               end
            end
            default: state <= S_WAIT;
         endcase
      end
   end

`ifdef SPI_READBACK_EN
   logic rd_mode;
   logic [7:0] rd;

   // The 8th falling edge completes the address: {sh[6:0], mosi} is addr, sh[6] is addr[7].
   always_ff @(posedge clk) begin
      if (!rst_n || cs_s) begin
         spi_miso <= 1'b0;
         rd_mode  <= 1'b0;
         rd       <= '0;
      end else if (state == S_SHIFT && sclk_fall && cnt == 5'd7 && sh[6]) begin
         rd       <= rd_data({sh[5:0], mosi_s}, reg_led, reg_mux, reg_dac, err_cnt);
         spi_miso <= rd_data({sh[5:0], mosi_s}, reg_led, reg_mux, reg_dac, err_cnt) >> 7;
         rd_mode  <= 1'b1;
      end else if (rd_mode && sclk_rise) begin
         spi_miso <= rd[7];
         rd       <= {rd[6:0], 1'b0};
      end
   end
`else
   assign spi_miso = 1'b0;
`endif
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed frames against spi_reg_ctrl with hand-computed expectations.
// Read checks are compiled in when SPI_READBACK_EN is defined.
module tb_spi_reg_ctrl;
   localparam int PULSE = 200;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic spi_clk = 1'b0;
   logic spi_cs = 1'b1;
   logic spi_special = 1'b0;
   logic spi_mosi = 1'b0;
   logic spi_miso, dac_rst_n, frame_err;
   logic [7:0] reg_mux, reg_led;
   logic [3:0] reg_dac;
   logic [7:0] rd_got;
   logic miso_any;
   int total = 0, bad = 0, fe_cnt = 0, lo_run = 0, last_lo = 0;

   always #5 clk = ~clk;

   spi_reg_ctrl #(.RST_PULSE_LEN(PULSE)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .spi_clk(spi_clk),
      .spi_cs(spi_cs),
      .spi_special(spi_special),
      .spi_mosi(spi_mosi),
      .spi_miso(spi_miso),
      .reg_mux(reg_mux),
      .reg_led(reg_led),
      .reg_dac(reg_dac),
      .dac_rst_n(dac_rst_n),
      .frame_err(frame_err)
   );

   always @(negedge clk) begin
      if (frame_err) fe_cnt++;
      if (!dac_rst_n) lo_run++;
      else if (lo_run != 0) begin
         last_lo = lo_run;
         lo_run = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bit(input logic b, input int idx);
      spi_mosi = b;
      spi_clk = 1'b1;
      ticks(4);
      if (idx >= 8 && idx < 16) rd_got[15-idx] = spi_miso;
      miso_any |= spi_miso;
      spi_clk = 1'b0;
      ticks(4);
   endtask

   task automatic frame_open(input logic [15:0] d, input int n = 16);
      miso_any = 1'b0;
      rd_got = '0;
      spi_special = 1'b0;
      spi_cs = 1'b0;
      ticks(4);
      for (int i = 0; i < n; i++) spi_bit(i < 16 ? d[15-i] : 1'b0, i);
   endtask

   task automatic frame(input logic [15:0] d, input int n = 16);
      frame_open(d, n);
      spi_cs = 1'b1;
      ticks(8);
   endtask

   task automatic wait_drst;
      for (int i = 0; i < 400 && !dac_rst_n; i++) ticks(1);
      chk("drst_release", dac_rst_n, 1);
      ticks(2);
   endtask

   initial begin
      ticks(5);
      chk("rst_mux", reg_mux, 8'h00);
      chk("rst_led", reg_led, 8'h00);
      chk("rst_dac", reg_dac, 4'h2);
      chk("rst_drst", dac_rst_n, 1);
      chk("rst_ferr", frame_err, 0);
      chk("rst_miso", spi_miso, 0);
      chk("rst_errcnt", dut.err_cnt, 0);
      rst_n = 1'b1;
      ticks(4);

      // Commit lands three clocks after cs rises: two sync stages then S_DONE.
      frame_open(16'h0805);
      spi_cs = 1'b1;
      ticks(2);
      chk("mux_early", reg_mux, 8'h00);
      ticks(1);
      chk("mux_commit", reg_mux, 8'h05);
      ticks(5);
      chk("mux_no_err", fe_cnt, 0);

      frame(16'h07FF, 15);
      chk("short_led", reg_led, 8'h00);
      chk("short_fe", fe_cnt, 1);
      chk("short_errcnt", dut.err_cnt, 1);
      frame(16'h07FF, 17);
      chk("long_led", reg_led, 8'h00);
      chk("long_fe", fe_cnt, 2);
      chk("long_errcnt", dut.err_cnt, 2);

      frame(16'h0B01);
      chk("drst_low", dac_rst_n, 0);
      wait_drst;
      chk("drst_len", last_lo, PULSE);
      // Second commit follows the first by 140 clocks, so low time is 140 + PULSE.
      frame(16'h0B01);
      frame(16'h0B01);
      wait_drst;
      chk("drst_retrig", last_lo, 140 + PULSE);

      frame_open(16'h090F, 8);
      spi_special = 1'b1;
      ticks(6);
      spi_cs = 1'b1;
      ticks(6);
      spi_special = 1'b0;
      ticks(4);
      chk("abort_dac", reg_dac, 4'h2);
      chk("abort_fe", fe_cnt, 3);
      chk("abort_errcnt", dut.err_cnt, 2);
      frame(16'h0909);
      chk("after_abort_dac", reg_dac, 4'h9);
      chk("after_abort_fe", fe_cnt, 3);

      frame_open(16'h07AA, 8);
      rst_n = 1'b0;
      ticks(3);
      rst_n = 1'b1;
      for (int i = 8; i < 16; i++) spi_bit(i[0], i);
      spi_cs = 1'b1;
      ticks(8);
      chk("midrst_led", reg_led, 8'h00);
      chk("midrst_dac", reg_dac, 4'h2);
      chk("midrst_fe", fe_cnt, 3);
      chk("midrst_errcnt", dut.err_cnt, 0);
      frame(16'h073C);
      chk("midrst_next_led", reg_led, 8'h3C);

      frame(16'h0833);
      frame(16'h090C);
      frame(16'h0FA4);
      chk("badkey_led", reg_led, 8'h3C);
      chk("badkey_mux", reg_mux, 8'h33);
      frame(16'h07FF, 15);
      chk("pre_srst_errcnt", dut.err_cnt, 1);
      frame(16'h0FA5);
      chk("srst_led", reg_led, 8'h00);
      chk("srst_mux", reg_mux, 8'h00);
      chk("srst_dac", reg_dac, 4'h2);
      chk("srst_errcnt", dut.err_cnt, 1);

      frame(16'h0A55);
      chk("ro_fe", fe_cnt, 4);
      chk("ro_led", reg_led, 8'h00);
      chk("ro_errcnt", dut.err_cnt, 1);

      frame(16'h07A5);
      frame(16'h8700);
      chk("read_led_kept", reg_led, 8'hA5);
      chk("read_fe", fe_cnt, 4);
`ifdef SPI_READBACK_EN
      chk("read_led_data", rd_got, 8'hA5);
      chk("read_miso_idle", spi_miso, 0);
      frame(16'h8A00);
      chk("read_errcnt_data", rd_got, 8'h01);
`else
      chk("read_miso_tied", miso_any, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
